// File: rtl/vec_mul_seq_ctrl.sv
// Batch sequencer for the vector-multiplier: optional weight reload, UB vector feed,
// and latency-matched Result SRAM writeback with a one-cycle done pulse.
module vec_mul_seq_ctrl #(
    parameter int ADDRESSSIZE   = 10,
    parameter int LEN_BW        = 11,
    parameter int ARRAY_LATENCY = 33,
    parameter int WLOAD_WORDS   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cfg_reload,
    input  logic [ADDRESSSIZE-1:0] cfg_src_base,
    input  logic [ADDRESSSIZE-1:0] cfg_dst_base,
    input  logic [LEN_BW-1:0]      cfg_num_vec,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   ub_read_valid,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   done
);
    localparam int LW = $clog2(WLOAD_WORDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;

    state_t state_reg, state_next;

    logic [ADDRESSSIZE-1:0]   src_base_reg, dst_base_reg;
    logic [LEN_BW-1:0]        num_vec_reg, rd_cnt_reg, wr_cnt_reg, wr_cnt_next;
    logic [LW-1:0]            load_cnt_reg;
    logic [ARRAY_LATENCY-1:0] dly_reg;

    logic                   accept, pop, last_pop, issue;
    logic [ADDRESSSIZE-1:0] issue_base, issue_idx;

    assign accept           = (state_reg == IDLE) && start;
    assign pop              = (state_reg == LOAD_W) && !fifo_empty && (load_cnt_reg < LW'(WLOAD_WORDS));
    assign last_pop         = pop && (load_cnt_reg == LW'(WLOAD_WORDS - 1));
    assign fifo_read_enable = pop;
    assign weight_reload    = (state_reg == LOAD_W);
    assign busy             = (state_reg != IDLE);
    assign done             = (state_reg == DONE);
    assign res_write_enable = dly_reg[ARRAY_LATENCY-1];
    assign wr_cnt_next      = wr_cnt_reg + (res_write_enable ? LEN_BW'(1) : LEN_BW'(0));
    assign res_address      = dst_base_reg + wr_cnt_reg[ADDRESSSIZE-1:0];

    // issue is decided one cycle early so the registered read strobe lines up with the state
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        issue_base = src_base_reg;
        issue_idx  = rd_cnt_reg[ADDRESSSIZE-1:0];
        case (state_reg)
            IDLE: begin
                issue_base = cfg_src_base;
                issue_idx  = '0;
                if (start) begin
                    if (cfg_reload) begin
                        state_next = LOAD_W;
                    end else if (cfg_num_vec != '0) begin
                        state_next = FEED;
                        issue      = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            LOAD_W: begin
                if (last_pop) begin
                    if (num_vec_reg != '0) begin
                        state_next = FEED;
                        issue      = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            FEED: begin
                if (rd_cnt_reg == num_vec_reg) state_next = DRAIN;
                else                           issue      = 1'b1;
            end
            DRAIN: begin
                // look at the post-write count so done follows the last write immediately
                if (wr_cnt_next == num_vec_reg) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_base_reg  <= '0;
            dst_base_reg  <= '0;
            num_vec_reg   <= '0;
            rd_cnt_reg    <= '0;
            wr_cnt_reg    <= '0;
            load_cnt_reg  <= '0;
            ub_read_valid <= 1'b0;
            ub_address    <= '0;
        end else begin
            if (accept) begin
                src_base_reg <= cfg_src_base;
                dst_base_reg <= cfg_dst_base;
                num_vec_reg  <= cfg_num_vec;
                load_cnt_reg <= '0;
                rd_cnt_reg   <= issue ? LEN_BW'(1) : '0;
                wr_cnt_reg   <= '0;
            end else begin
                if (pop)   load_cnt_reg <= load_cnt_reg + LW'(1);
                if (issue) rd_cnt_reg   <= rd_cnt_reg + LEN_BW'(1);
                wr_cnt_reg <= wr_cnt_next;
            end
            ub_read_valid <= issue;
            ub_address    <= issue ? (issue_base + issue_idx) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_reg <= '0;
        end else begin
            dly_reg[0] <= ub_read_valid;
            for (int i = 1; i < ARRAY_LATENCY; i++) dly_reg[i] <= dly_reg[i-1];
        end
    end
endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// Directed table-driven bench for vec_mul_seq_ctrl with hand-computed cycle schedules
// (cycle 1 is the cycle right after the edge that accepts start).
module tb_vec_mul_seq_ctrl;
    localparam int AW = 10;
    localparam int LB = 11;

    logic          clk = 1'b0;
    logic          rst, start, cfg_reload, fifo_empty;
    logic [AW-1:0] cfg_src_base, cfg_dst_base;
    logic [LB-1:0] cfg_num_vec;
    logic          fifo_read_enable, weight_reload, ub_read_valid, res_write_enable, busy, done;
    logic [AW-1:0] ub_address, res_address;

    vec_mul_seq_ctrl #(.ADDRESSSIZE(AW), .LEN_BW(LB), .ARRAY_LATENCY(33), .WLOAD_WORDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_reload(cfg_reload),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_num_vec(cfg_num_vec),
        .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable), .weight_reload(weight_reload),
        .ub_address(ub_address), .ub_read_valid(ub_read_valid), .res_write_enable(res_write_enable),
        .res_address(res_address), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    reload;
        int    src, dst, n;
        int    e_lo, e_hi;   // fifo_empty high in cycles e_lo..e_hi
        int    spur;         // cycle of an extra start pulse, 0 = none
        int    x_rd1, x_wr1, x_done, x_pops, x_wl;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_q[$];
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int rd1 = -1, rdl = -1, wr1 = -1, wrl = -1, done_c = -1;
        int pops = 0, nwl = 0, nbusy = 0, ndone = 0, aerr = 0;
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        cfg_reload   = v.reload;
        cfg_src_base = AW'(v.src);
        cfg_dst_base = AW'(v.dst);
        cfg_num_vec  = LB'(v.n);
        fifo_empty   = (1 >= v.e_lo) && (1 <= v.e_hi);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        cfg_reload   = ~v.reload;
        cfg_src_base = AW'(v.src + 333);
        cfg_dst_base = AW'(v.dst + 444);
        cfg_num_vec  = LB'(v.n + 7);
        for (int c = 1; c <= 200 && done_c < 0; c++) begin
            @(negedge clk);
            if (ub_read_valid) begin
                if (rd1 < 0) rd1 = c;
                rdl = c;
                rd_q.push_back(ub_address);
            end
            if (res_write_enable) begin
                if (wr1 < 0) wr1 = c;
                wrl = c;
                wr_q.push_back(res_address);
            end
            if (fifo_read_enable) pops++;
            if (weight_reload) nwl++;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_c = c;
            end
            fifo_empty = (c + 1 >= v.e_lo) && (c + 1 <= v.e_hi);
            start      = (c == v.spur);
            if (c == v.spur) begin
                cfg_reload  = 1'b0;
                cfg_num_vec = LB'(3);
            end
        end
        fifo_empty = 1'b0;
        start      = 1'b0;
        foreach (rd_q[i]) if (int'(rd_q[i]) != (v.src + i) % 1024) aerr++;
        foreach (wr_q[i]) if (int'(wr_q[i]) != (v.dst + i) % 1024) aerr++;
        chk({v.name, " rd_first"}, rd1, v.x_rd1);
        chk({v.name, " rd_last"}, rdl, (v.n > 0) ? v.x_rd1 + v.n - 1 : -1);
        chk({v.name, " rd_count"}, rd_q.size(), v.n);
        chk({v.name, " wr_first"}, wr1, v.x_wr1);
        chk({v.name, " wr_last"}, wrl, (v.n > 0) ? v.x_wr1 + v.n - 1 : -1);
        chk({v.name, " wr_count"}, wr_q.size(), v.n);
        chk({v.name, " addr_errs"}, aerr, 0);
        chk({v.name, " done_cycle"}, done_c, v.x_done);
        chk({v.name, " done_pulses"}, ndone, 1);
        chk({v.name, " busy_cycles"}, nbusy, v.x_done);
        chk({v.name, " pops"}, pops, v.x_pops);
        chk({v.name, " wreload_cycles"}, nwl, v.x_wl);
        $display("vec %s: rd %0d..%0d wr %0d..%0d done %0d pops %0d", v.name, rd1, rdl, wr1, wrl, done_c, pops);
    endtask

    initial begin
        int exp_rd[5] = '{1022, 1023, 0, 1, 2};
        int exp_wr[5] = '{1020, 1021, 1022, 1023, 0};
        int nw, nd;
        //           name       rl src   dst   n   elo ehi spur rd1 wr1 done pops wl
        tbl[0] = '{"plain4",  1'b0, 0,    0,    4,  0, -1, 0,   1,  34, 38, 0,  0};
        tbl[1] = '{"reload3", 1'b1, 5,    100,  3,  0, -1, 0,   17, 50, 53, 16, 16};
        tbl[2] = '{"stall",   1'b1, 0,    0,    2,  3,  7, 0,   22, 55, 57, 16, 21};
        tbl[3] = '{"wrap",    1'b0, 1022, 1020, 5,  0, -1, 0,   1,  34, 39, 0,  0};
        tbl[4] = '{"zero",    1'b0, 12,   13,   0,  0, -1, 0,   -1, -1, 1,  0,  0};
        tbl[5] = '{"zero_rl", 1'b1, 12,   13,   0,  0, -1, 0,   -1, -1, 17, 16, 16};
        tbl[6] = '{"long40",  1'b0, 7,    9,    40, 0, -1, 10,  1,  34, 74, 0,  0};

        rst = 1'b1; start = 1'b0; cfg_reload = 1'b0; fifo_empty = 1'b0;
        cfg_src_base = '0; cfg_dst_base = '0; cfg_num_vec = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", int'({ub_read_valid, res_write_enable, busy, done, fifo_read_enable,
                                   weight_reload, ub_address, res_address}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", int'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i]);
            if (i == 3) begin
                for (int j = 0; j < 5; j++) begin
                    chk($sformatf("wrap rd_addr[%0d]", j), (j < rd_q.size()) ? int'(rd_q[j]) : -1, exp_rd[j]);
                    chk($sformatf("wrap wr_addr[%0d]", j), (j < wr_q.size()) ? int'(wr_q[j]) : -1, exp_wr[j]);
                end
            end
        end

        // abort an N=40 run in the middle of FEED
        @(negedge clk);
        cfg_reload = 1'b0; cfg_src_base = AW'(50); cfg_dst_base = AW'(60); cfg_num_vec = LB'(40);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("abort feeding", int'(ub_read_valid), 1);
        #1 rst = 1'b1;
        #1 chk("abort outputs", int'({ub_read_valid, res_write_enable, busy, done, fifo_read_enable,
                                      weight_reload, ub_address, res_address}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nw = 0; nd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (res_write_enable) nw++;
            if (done) nd++;
        end
        chk("abort writes", nw, 0);
        chk("abort done", nd, 0);
        $display("abort: writes %0d done %0d after reset", nw, nd);
        run_vec(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_mul_seq_ctrl.md
Name: vec_mul_seq_ctrl

Overview:
Parametrised batch sequencer for the vector-multiplier datapath. It replaces the fixed start/count logic and the hard-wired 4-bit result addressing in the top level.
- One start command optionally reloads weights from the Weight FIFO.
- It then streams a programmable range of Unified Buffer vectors into the array.
- It writes each array result to a programmable Result SRAM range after a parametrised array latency, then pulses done.
- It sits between the top-level command pins and the UB, Weight FIFO, array and Result SRAM.

Parameters:
- ADDRESSSIZE, 10: UB and Result SRAM address width.
- LEN_BW, 11: width of the vector-count field, so counts up to 2^ADDRESSSIZE are possible.
- ARRAY_LATENCY, 33: cycles from a UB read address being issued to the matching result being valid at the array output; must be ≥ 1.
- WLOAD_WORDS, 16: number of FIFO words popped per weight reload; must be ≥ 1.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: command strobe; sampled only in IDLE.
- cfg_reload, input, 1: 1 = perform a weight load before the feed phase.
- cfg_src_base, input, ADDRESSSIZE: first UB address to read.
- cfg_dst_base, input, ADDRESSSIZE: first Result SRAM address to write.
- cfg_num_vec, input, LEN_BW: number of vectors to process.
- fifo_empty, input, 1: Weight FIFO empty flag.
- fifo_read_enable, output, 1: FIFO pop strobe.
- weight_reload, output, 1: array weight-shift enable.
- ub_address, output, ADDRESSSIZE: UB read address.
- ub_read_valid, output, 1: ub_address is a live read this cycle.
- res_write_enable, output, 1: Result SRAM write strobe.
- res_address, output, ADDRESSSIZE: Result SRAM write address.
- busy, output, 1: command in progress.
- done, output, 1: one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All counters and the latency delay line are cleared.
  - All outputs are 0.
  - Reset asserted mid-command aborts the command: no further writes and no done pulse.
- Configuration capture:
  - The cfg_* inputs are latched on the edge where start=1 in IDLE.
  - Later changes to cfg_* are ignored until the next command.
  - start is ignored whenever busy=1.
- States: IDLE, LOAD_W, FEED, DRAIN, DONE.
  - busy = (state != IDLE).
  - done = (state == DONE).
- IDLE:
  - start with cfg_reload=1 goes to LOAD_W.
  - start with cfg_reload=0 and num_vec>0 goes to FEED.
  - start with cfg_reload=0 and num_vec=0 goes to DONE.
- LOAD_W:
  - weight_reload=1 throughout the state.
  - fifo_read_enable = !fifo_empty && (load_cnt < WLOAD_WORDS); this is combinational from the registered state.
  - load_cnt increments on each pop. An empty FIFO stalls the load with no timeout.
  - The edge that completes the WLOAD_WORDS-th pop exits to FEED, or to DONE if num_vec=0.
- FEED:
  - One vector is issued per cycle: ub_read_valid=1 and ub_address = src_base + rd_cnt, modulo 2^ADDRESSSIZE.
  - After num_vec issues the state goes to DRAIN.
  - Outputs are registered, so the first issue appears in the cycle after the state transition.
- Writeback path, independent of state:
  - ub_read_valid feeds an ARRAY_LATENCY-stage shift register.
  - res_write_enable equals the delay-line output.
  - res_address = dst_base + wr_cnt, modulo 2^ADDRESSSIZE; wr_cnt increments on each write.
  - Writes overlap FEED when num_vec > ARRAY_LATENCY.
- DRAIN: waits until wr_cnt == num_vec, then goes to DONE.
- DONE: lasts one cycle with done=1, then goes to IDLE.
- Timing, no reload, start sampled at edge k:
  - ub_read_valid is high in cycles k+1 .. k+N.
  - res_write_enable is high in cycles k+1+L .. k+N+L.
  - done is high in cycle k+N+L+1.
  - Total = N+L+1 cycles.
- Timing with reload: the schedule above is shifted by the LOAD_W duration, which is WLOAD_WORDS cycles when the FIFO is never empty.
- Back-to-back commands: start in the cycle immediately after done is accepted. Counters are cleared on command accept.

Test Plan:
1. Reset is released; start with reload=0, src=0, dst=0, N=4, L=33 → reads at addresses 0..3 in cycles 1..4, writes at 0..3 in cycles 34..37, done in cycle 38, busy high in cycles 1..38.
2. reload=1, WLOAD_WORDS=16, FIFO non-empty → 16 consecutive fifo_read_enable pulses with weight_reload=1, then the first ub_read_valid in the next cycle, then done at (16 + N + L + 1) cycles.
3. reload=1 with fifo_empty held for cycles 3..7 → no pop while empty, load_cnt frozen, total pops still exactly 16, and completion delayed by 5 cycles.
4. src=1022, dst=1020, N=5 → ub_address sequence 1022, 1023, 0, 1, 2 and res_address sequence 1020..1023, 0.
5. N=0, reload=0 → done in cycle 1 with no reads or writes; a second start pulse during busy in a long N=40 run is ignored, giving exactly 40 writes.
6. rst asserted during FEED of an N=40 run → all outputs 0 in the same cycle, no subsequent res_write_enable, no done; a new start after reset behaves as in scenario 1.
